// File: rtl/vga_timing_compositor_if.sv
// Signal bundle between the raster compositor, the layer renderers and the VGA pins.
// The master modport is the compositor side; the slave modport is the renderer/board side.
interface vga_timing_compositor_if #(
    parameter int XW      = 11,
    parameter int YW      = 10,
    parameter int NLAYERS = 3,
    parameter int CW      = 3,
    parameter int FCW     = 8
);
    logic                  pix_en;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [NLAYERS*CW-1:0] layer_rgb;
    logic [NLAYERS-1:0]    layer_dav;
    logic [NLAYERS-1:0]    layer_mask;
    logic [CW-1:0]         bg_color;
    logic                  vga_hs;
    logic                  vga_vs;
    logic [CW-1:0]         vga_rgb;
    logic                  vga_de;
    logic                  sof;
    logic [FCW-1:0]        frame_cnt;

    modport master (
        input  pix_en, layer_rgb, layer_dav, layer_mask, bg_color,
        output x, y, vga_hs, vga_vs, vga_rgb, vga_de, sof, frame_cnt
    );

    modport slave (
        output pix_en, layer_rgb, layer_dav, layer_mask, bg_color,
        input  x, y, vga_hs, vga_vs, vga_rgb, vga_de, sof, frame_cnt
    );
endinterface

// File: rtl/vga_timing_compositor.sv
// Parametrised VGA raster engine: x/y counters, sync/blank generation, and a fixed-priority
// layer compositor whose timing flags are delayed to line up with the renderer latency.
module vga_timing_compositor #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   NLAYERS  = 3,
    parameter int   CW       = 3,
    parameter int   LAT      = 1,
    parameter int   XW       = 11,
    parameter int   YW       = 10,
    parameter int   FCW      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    vga_timing_compositor_if.master        bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    // Flags are carried active-high; sync polarity is applied only at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } flags_t;

    logic [XW-1:0]  x_r;
    logic [YW-1:0]  y_r;
    logic [FCW-1:0] frame_cnt_r;
    logic           hs_r;
    logic           vs_r;
    logic [CW-1:0]  rgb_r;
    logic           de_r;
    logic           sof_s;
    flags_t         cur_s;
    flags_t         dly_s;
    logic [CW-1:0]  rgb_next_s;

    // Lowest enabled index wins; scanning downward lets it overwrite higher-index winners.
    function automatic logic [CW-1:0] pick_colour(
        input logic [NLAYERS*CW-1:0] rgb,
        input logic [NLAYERS-1:0]    sel,
        input logic [CW-1:0]         bg
    );
        logic [CW-1:0] c;
        c = bg;
        for (int i = NLAYERS - 1; i >= 0; i--) begin
            if (sel[i]) begin
                c = rgb[i*CW +: CW];
            end
        end
        return c;
    endfunction

    assign sof_s = bus.pix_en && (x_r == X_LAST) && (y_r == Y_LAST);

    // Raster position counters, advancing one pixel per strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r <= '0;
            y_r <= '0;
        end else if (bus.pix_en) begin
            if (x_r == X_LAST) begin
                x_r <= '0;
                if (y_r == Y_LAST) begin
                    y_r <= '0;
                end else begin
                    y_r <= y_r + 1'b1;
                end
            end else begin
                x_r <= x_r + 1'b1;
            end
        end
    end

    // Completed-frame counter, stepping on the same edge as the frame wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_r <= '0;
        end else if (sof_s) begin
            frame_cnt_r <= frame_cnt_r + 1'b1;
        end
    end

    // Timing flags for the current coordinates.
    always_comb begin
        cur_s    = '0;
        cur_s.de = (int'(x_r) < H_ACTIVE) && (int'(y_r) < V_ACTIVE);
        cur_s.hs = (int'(x_r) >= HS_START) && (int'(x_r) < HS_END);
        cur_s.vs = (int'(y_r) >= VS_START) && (int'(y_r) < VS_END);
    end

    generate
        if (LAT == 0) begin : g_no_delay
            assign dly_s = cur_s;
        end else begin : g_delay
            flags_t stage_r [LAT];

            // Flag pipeline matching the renderer latency, advanced only on strobes.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        stage_r[i] <= '0;
                    end
                end else if (bus.pix_en) begin
                    stage_r[0] <= cur_s;
                    for (int i = 1; i < LAT; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dly_s = stage_r[LAT-1];
        end
    endgenerate

    // Composite colour, blanked whenever the delayed pixel lies outside the active area.
    always_comb begin
        rgb_next_s = '0;
        if (dly_s.de) begin
            rgb_next_s = pick_colour(bus.layer_rgb, bus.layer_dav & bus.layer_mask, bus.bg_color);
        end else begin
            rgb_next_s = '0;
        end
    end

    // Pin-facing output register with sync polarity applied.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_r  <= ~HS_POL;
            vs_r  <= ~VS_POL;
            rgb_r <= '0;
            de_r  <= 1'b0;
        end else if (bus.pix_en) begin
            hs_r  <= dly_s.hs ? HS_POL : ~HS_POL;
            vs_r  <= dly_s.vs ? VS_POL : ~VS_POL;
            rgb_r <= rgb_next_s;
            de_r  <= dly_s.de;
        end
    end

    assign bus.x         = x_r;
    assign bus.y         = y_r;
    assign bus.sof       = sof_s;
    assign bus.frame_cnt = frame_cnt_r;
    assign bus.vga_hs    = hs_r;
    assign bus.vga_vs    = vs_r;
    assign bus.vga_rgb   = rgb_r;
    assign bus.vga_de    = de_r;
endmodule

// File: tb/tb_vga_timing_compositor.sv
// Scoreboard bench: a reduced-raster 3-layer instance (LAT=1, FCW=2) checked through expectation
// queues, plus a tiny 1-layer LAT=0 instance compared cycle by cycle against an inline model.
module tb_vga_timing_compositor;
    localparam int MH_A = 20, MH_F = 4, MH_S = 6, MH_B = 3, MH_T = 33;
    localparam int MV_A = 8,  MV_F = 2, MV_S = 2, MV_B = 3, MV_T = 15;
    localparam int SH_T = 14, SV_T = 7;

    typedef struct packed { logic hs; logic vs; logic de; logic [2:0] rgb; } pix_t;
    typedef struct packed { logic [5:0] x; logic [3:0] y; logic sof; logic [1:0] fc; } xy_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_timing_compositor_if #(.XW(6), .YW(4), .NLAYERS(3), .CW(3), .FCW(2)) bm ();
    vga_timing_compositor_if #(.XW(4), .YW(3), .NLAYERS(1), .CW(3), .FCW(8)) bs ();

    vga_timing_compositor #(
        .H_ACTIVE(MH_A), .H_FP(MH_F), .H_SYNC(MH_S), .H_BP(MH_B),
        .V_ACTIVE(MV_A), .V_FP(MV_F), .V_SYNC(MV_S), .V_BP(MV_B),
        .HS_POL(1'b1), .VS_POL(1'b1), .NLAYERS(3), .CW(3), .LAT(1),
        .XW(6), .YW(4), .FCW(2)
    ) u_dut (.clk(clk), .rst(rst), .bus(bm.master));

    vga_timing_compositor #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .NLAYERS(1), .CW(3), .LAT(0),
        .XW(4), .YW(3), .FCW(8)
    ) u_small (.clk(clk), .rst(rst), .bus(bs.master));

    pix_t q_pix[$];
    xy_t  q_xy[$];
    int   total = 0;
    int   bad = 0;
    bit   chk_on = 1'b0;
    bit   alt_on = 1'b0;

    // Stimulus-side model of the raster position and the one-deep flag pipeline.
    int         mx = 0, my = 0, mfc = 0, sof_exp = 0;
    logic [2:0] pf = 3'b000;

    // Layer colours are 1/2/3 for layers 0/1/2 and the background is 6.
    logic [2:0] t_dav [8] = '{3'b111, 3'b111, 3'b111, 3'b000, 3'b110, 3'b101, 3'b100, 3'b011};
    logic [2:0] t_msk [8] = '{3'b111, 3'b110, 3'b100, 3'b111, 3'b111, 3'b011, 3'b011, 3'b000};
    logic [2:0] t_exp [8] = '{3'd1,   3'd2,   3'd3,   3'd6,   3'd2,   3'd1,   3'd6,   3'd6};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // {hs, vs, de} active-high for the reduced raster
    function automatic logic [2:0] m_flags(input int fx, input int fy);
        return {fx >= MH_A + MH_F && fx < MH_A + MH_F + MH_S,
                fy >= MV_A + MV_F && fy < MV_A + MV_F + MV_S,
                fx < MH_A && fy < MV_A};
    endfunction

    function automatic logic [2:0] s_flags(input int fx, input int fy);
        return {fx >= 10 && fx < 12, fy == 5, fx < 8 && fy < 4};
    endfunction

    task automatic step(input bit pe, input logic [2:0] dav, input logic [2:0] msk, input logic [2:0] col);
        xy_t  ex;
        pix_t ep;
        @(posedge clk); #1;
        bm.pix_en     = pe;
        bm.layer_dav  = dav;
        bm.layer_mask = msk;
        if (chk_on) begin
            ex.x   = 6'(mx);
            ex.y   = 4'(my);
            ex.sof = pe && mx == MH_T - 1 && my == MV_T - 1;
            ex.fc  = 2'(mfc);
            if (ex.sof) sof_exp++;
            q_xy.push_back(ex);
            if (pe) begin
                ep.hs  = pf[2];
                ep.vs  = pf[1];
                ep.de  = pf[0];
                ep.rgb = pf[0] ? col : 3'd0;
                q_pix.push_back(ep);
            end
        end
        if (pe) begin
            pf = m_flags(mx, my);
            if (mx == MH_T - 1) begin
                mx = 0;
                if (my == MV_T - 1) begin
                    my  = 0;
                    mfc = (mfc + 1) % 4;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, bm.x, 0);
        chk({tag, "_y"}, bm.y, 0);
        chk({tag, "_hs"}, bm.vga_hs, 0);
        chk({tag, "_vs"}, bm.vga_vs, 0);
        chk({tag, "_rgb"}, bm.vga_rgb, 0);
        chk({tag, "_de"}, bm.vga_de, 0);
        chk({tag, "_sof"}, bm.sof, 0);
        chk({tag, "_fc"}, bm.frame_cnt, 0);
        chk({tag, "_small_x"}, bs.x, 0);
        chk({tag, "_small_vs"}, bs.vga_vs, 1);
    endtask

    task automatic release_rst();
        @(posedge clk); #1;
        bm.pix_en = 1'b0;
        rst       = 1'b1;
        @(negedge clk); #1;
        chk_on = 1'b1;
    endtask

    // Monitor state
    pix_t       last_exp = '0;
    bit         armed = 1'b0, pe_prev = 1'b0;
    int         sof_seen = 0, cyc = 0, last_rise = 0, hs_len = 0, alt_w = 0;
    bit         hs_q = 1'b0, hs_alt = 1'b0, rise_ok = 1'b0;
    int         sx = 0, sy = 0, s_cnt = 0;
    logic [2:0] sf = 3'b000;

    always @(negedge clk) begin
        xy_t ex;
        cyc++;
        if (chk_on) begin
            if (q_xy.size() == 0) begin
                chk("xy_queue_empty", 1, 0);
            end else begin
                ex = q_xy.pop_front();
                chk("x", bm.x, ex.x);
                chk("y", bm.y, ex.y);
                chk("sof", bm.sof, ex.sof);
                chk("frame_cnt", bm.frame_cnt, ex.fc);
            end
            if (bm.sof) sof_seen++;
            if (armed) begin
                if (pe_prev) begin
                    if (q_pix.size() == 0) chk("pix_queue_empty", 1, 0);
                    else last_exp = q_pix.pop_front();
                end
                chk("vga_hs", bm.vga_hs, last_exp.hs);
                chk("vga_vs", bm.vga_vs, last_exp.vs);
                chk("vga_de", bm.vga_de, last_exp.de);
                chk("vga_rgb", bm.vga_rgb, last_exp.rgb);
            end
            armed   = 1'b1;
            pe_prev = bm.pix_en;
            // sync width and line period under a half-rate strobe
            if (bm.vga_hs && !hs_q) begin
                if (alt_on && rise_ok) chk("alt_line_period", cyc - last_rise, 2 * MH_T);
                rise_ok   = alt_on;
                last_rise = cyc;
                hs_len    = 0;
                hs_alt    = alt_on;
            end
            if (bm.vga_hs) begin
                hs_len++;
            end else if (hs_q && hs_alt && alt_on) begin
                chk("alt_hs_width", hs_len, 2 * MH_S);
                alt_w++;
            end
            hs_q = bm.vga_hs;
        end else begin
            armed    = 1'b0;
            last_exp = '0;
            hs_q     = 1'b0;
            rise_ok  = 1'b0;
        end

        if (rst && s_cnt < 3 * SH_T * SV_T) begin
            chk("s_x", bs.x, sx);
            chk("s_y", bs.y, sy);
            chk("s_hs", bs.vga_hs, sf[2]);
            chk("s_vs", bs.vga_vs, !sf[1]);
            chk("s_de", bs.vga_de, sf[0]);
            chk("s_rgb", bs.vga_rgb, sf[0] ? 5 : 0);
            sf = s_flags(sx, sy);
            if (sx == SH_T - 1) begin
                sx = 0;
                sy = (sy == SV_T - 1) ? 0 : sy + 1;
            end else begin
                sx++;
            end
            s_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst            = 1'b1;
        bm.pix_en      = 1'b0;
        bm.layer_rgb   = {3'd3, 3'd2, 3'd1};
        bm.layer_dav   = 3'b000;
        bm.layer_mask  = 3'b000;
        bm.bg_color    = 3'd6;
        bs.pix_en      = 1'b1;
        bs.layer_rgb   = 3'd5;
        bs.layer_dav   = 1'b1;
        bs.layer_mask  = 1'b1;
        bs.bg_color    = 3'd2;
        #1 rst = 1'b0;
        #1 check_reset("por");
        repeat (3) @(posedge clk);
        release_rst();

        // priority and mask patterns, each spanning a full line
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 35; j++) step(1'b1, t_dav[k], t_msk[k], t_exp[k]);
        end

        // run through five frame wraps (frame_cnt 1,2,3,0,1)
        n = 0;
        while (sof_exp < 5 && n < 5000) begin
            step(1'b1, t_dav[(n / 37) % 8], t_msk[(n / 37) % 8], t_exp[(n / 37) % 8]);
            n++;
        end
        chk("five_frames_reached", sof_exp, 5);

        // strobe every other clk with junk layer inputs on disabled cycles
        for (int j = 0; j < 200; j++) begin
            if (j == 4) alt_on = 1'b1;
            step(1'b1, t_dav[(j / 30) % 8], t_msk[(j / 30) % 8], t_exp[(j / 30) % 8]);
            step(1'b0, 3'($urandom), 3'($urandom), 3'd0);
        end
        alt_on = 1'b0;
        chk("alt_hs_width_seen", int'(alt_w > 2), 1);

        // asynchronous reset mid-line, mid-frame
        n = 0;
        while (!(mx == 10 && my == 6) && n < 2000) begin
            step(1'b1, t_dav[0], t_msk[0], t_exp[0]);
            n++;
        end
        @(posedge clk); #3;
        chk_on = 1'b0;
        rst    = 1'b0;
        #1 check_reset("mid");
        q_xy.delete();
        q_pix.delete();
        mx = 0; my = 0; mfc = 0; pf = 3'b000;
        repeat (2) @(posedge clk);
        #1 check_reset("hold");
        release_rst();
        sof_exp  = 0;
        sof_seen = 0;
        for (int j = 0; j < MH_T * MV_T + 10; j++) begin
            step(1'b1, t_dav[(j / 40) % 8], t_msk[(j / 40) % 8], t_exp[(j / 40) % 8]);
        end
        step(1'b0, 3'b000, 3'b000, 3'd0);
        @(negedge clk); #1;
        chk_on = 1'b0;
        chk("sof_after_reset", sof_seen, 1);
        chk("sof_after_reset_model", sof_exp, 1);
        chk("queues_drained", q_pix.size() + q_xy.size(), 0);
        chk("small_model_cycles", s_cnt, 3 * SH_T * SV_T);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
